seg7_display_driver: RTL and testbench

- Downstream consumer of the CPU's 8-bit output register. Drives a 4-digit multiplexed seven-segment display on the FPGA test socket.
- Converts the output value to decimal (serial double-dabble) or hex, and commits digits atomically so the display never shows a torn value.
- Time-multiplexes the anodes from the board clock.

---
 rtl/seg7_display_driver_pkg.sv | 32 +++
 rtl/bin_to_bcd_serial.sv | 67 ++++++
 rtl/seg7_display_driver.sv | 187 ++++++++++++++++++
 tb/tb_seg7_display_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_display_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_display_driver_pkg
//   Shared definitions for the seven-segment display driver:
//   - conversion FSM state encoding (2-bit)
//   - active-low segment lookup table ({g,f,e,d,c,b,a}) and the blank pattern
//   - default refresh period in board-clock cycles per digit slot
// -----------------------------------------------------------------------------
package seg7_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs 0-9, A, b, C, d, E, F; a 0 bit lights the segment.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // 1 ms per digit slot at 100 MHz.
  localparam int DEFAULT_REFRESH_COUNT = 100000;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
//   Serial double-dabble converter, one input bit per clock.
//   Ports:
//     clk, reset    clock and synchronous active-high reset (abandons work)
//     start         load value, clear the BCD accumulator
//     value         binary input, sampled on start
//     done          high during the cycle whose edge performs the final shift
//     hundreds/tens/units  BCD result, valid once the final shift has happened
//   Three BCD nibbles cover an 8-bit input (0..255).
// -----------------------------------------------------------------------------
module bin_to_bcd_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  done,
  output logic [3:0]            hundreds,
  output logic [3:0]            tens,
  output logic [3:0]            units
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [11:0]           bcd_q;
  logic [11:0]           bcd_adj;
  logic [CNT_W-1:0]      bits_left_q;

  // Add-3 correction: any nibble >= 5 would overflow past 9 when doubled.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bcd_q       <= '0;
      bits_left_q <= '0;
    end else if (start) begin
      shift_q     <= value;
      bcd_q       <= '0;
      bits_left_q <= CNT_W'(DATA_WIDTH);
    end else if (bits_left_q != '0) begin
      bcd_q       <= {bcd_adj[10:0], shift_q[DATA_WIDTH-1]};
      shift_q     <= shift_q << 1;
      bits_left_q <= bits_left_q - CNT_W'(1);
    end
  end

  assign done     = (bits_left_q == CNT_W'(1));
  assign units    = bcd_q[3:0];
  assign tens     = bcd_q[7:4];
  assign hundreds = bcd_q[11:8];

endmodule

// File: rtl/seg7_display_driver.sv
// -----------------------------------------------------------------------------
// seg7_display_driver
//   Shows an output-register value on a 4-digit multiplexed seven-segment
//   display, in decimal (serial double-dabble) or hex. Converted digits are
//   committed to the digit register in a single edge, so a scan never mixes
//   two values.
//   Ports:
//     boardCLK    board clock (single domain)
//     reset       synchronous, active-high
//     valueIn     value to display
//     hexMode     1 = hex, 0 = decimal
//     blankZeros  1 = blank leading zeros (digit 0 never blanked)
//     segments    active-low {g,f,e,d,c,b,a}, registered with anodes
//     anodes      active-low one-hot, bit 0 = rightmost digit
//     busy        high while a conversion is in flight (LOAD/SHIFT/DONE)
// -----------------------------------------------------------------------------
module seg7_display_driver
  import seg7_display_driver_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = DEFAULT_REFRESH_COUNT
) (
  input  logic                  boardCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] valueIn,
  input  logic                  hexMode,
  input  logic                  blankZeros,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  busy
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_COUNT);

  // Conversion control
  state_t                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       captured_value_q;
  logic                        captured_mode_q;
  logic                        dirty_q;
  logic                        capture, conv_start, commit;
  logic                        conv_done;
  logic [3:0]                  bcd_h, bcd_t, bcd_u;
  logic [7:0]                  hex_src;
  logic [NUM_DIGITS-1:0][3:0]  commit_digits;

  // Display side
  logic [NUM_DIGITS-1:0][3:0]  digits_q;
  logic                        shown_q;     // a commit has happened since reset
  logic [NUM_DIGITS-1:0]       zero_from;   // digit i and everything above are 0
  logic [CNT_W-1:0]            refresh_q;
  logic                        refresh_wrap;
  logic [IDX_W-1:0]            scan_idx_q, next_idx;
  logic [6:0]                  next_seg;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    conv_start = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Inputs that moved while busy are picked up here on re-compare.
        if (dirty_q || (valueIn != captured_value_q) || (hexMode != captured_mode_q)) begin
          capture = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (captured_mode_q) begin
          state_d = ST_DONE;
        end else begin
          conv_start = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (conv_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bin_to_bcd_serial #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bcd (
    .clk      (boardCLK),
    .reset    (reset),
    .start    (conv_start),
    .value    (captured_value_q),
    .done     (conv_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u)
  );

  // Digits to commit: hex {0,0,hi,lo}; decimal {0,hundreds,tens,units}.
  always_comb begin
    hex_src       = 8'(captured_value_q);
    commit_digits = '0;
    if (captured_mode_q) begin
      commit_digits[0] = hex_src[3:0];
      commit_digits[1] = hex_src[7:4];
    end else begin
      commit_digits[0] = bcd_u;
      commit_digits[1] = bcd_t;
      commit_digits[2] = bcd_h;
    end
  end

  always_ff @(posedge boardCLK) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      captured_value_q <= '0;
      captured_mode_q  <= 1'b0;
      dirty_q          <= 1'b1;   // forces a conversion right after reset
      // NOTE: the digit register is small and drives the display directly, so
      // it is reset like any control register rather than left undefined.
      digits_q         <= '0;
      shown_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        captured_value_q <= valueIn;
        captured_mode_q  <= hexMode;
        dirty_q          <= 1'b0;
      end
      if (commit) begin
        digits_q <= commit_digits;
        shown_q  <= 1'b1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Scan and segment encoding
  // ---------------------------------------------------------------------------
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run && (digits_q[i] == 4'd0);
      zero_from[i] = run;
    end
  end

  assign refresh_wrap = (refresh_q == CNT_W'(REFRESH_COUNT - 1));

  // Segments are computed for the slot about to start, so they are loaded on
  // the same edge as the anode they belong to.
  always_comb begin
    next_idx = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    if (!shown_q || (blankZeros && (next_idx != '0) && zero_from[next_idx])) begin
      next_seg = SEG_BLANK;
    end else begin
      next_seg = seg_encode(digits_q[next_idx]);
    end
  end

  always_ff @(posedge boardCLK) begin
    if (reset) begin
      refresh_q  <= '0;
      scan_idx_q <= '0;
      anodes     <= '1;
      segments   <= SEG_BLANK;
    end else if (refresh_wrap) begin
      refresh_q  <= '0;
      scan_idx_q <= next_idx;
      anodes     <= ~(NUM_DIGITS'(1) << next_idx);
      segments   <= next_seg;
    end else begin
      refresh_q  <= refresh_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_driver
//   Scoreboard bench: stimulus applies a display request, checks busy length,
//   then queues the expected digit glyphs; a monitor compares each new scan
//   slot against the queued expectation and checks scan order and slot length.
// -----------------------------------------------------------------------------
module tb_seg7_display_driver;

  localparam int DW = 8;
  localparam int ND = 4;
  localparam int RC = 4;

  logic          boardCLK = 1'b0;
  logic          reset;
  logic [DW-1:0] valueIn;
  logic          hexMode;
  logic          blankZeros;
  logic [6:0]    segments;
  logic [ND-1:0] anodes;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 boardCLK = ~boardCLK;

  seg7_display_driver #(
    .DATA_WIDTH    (DW),
    .NUM_DIGITS    (ND),
    .REFRESH_COUNT (RC)
  ) dut (
    .boardCLK   (boardCLK),
    .reset      (reset),
    .valueIn    (valueIn),
    .hexMode    (hexMode),
    .blankZeros (blankZeros),
    .segments   (segments),
    .anodes     (anodes),
    .busy       (busy)
  );

  typedef logic [3:0][6:0] disp_t;
  typedef struct packed {
    disp_t a;
    disp_t b;   // alternative accepted glyph set (equal to a unless a change is in flight)
  } exp_t;

  exp_t exp_q[$];
  int   slots_left = 0;

  logic [6:0] ref_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model state: the last value/mode the display was converted for.
  int cap_v   = -1;
  bit cap_hex = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_slot(input int idx, input logic [6:0] act,
                            input logic [6:0] ea, input logic [6:0] eb);
    total++;
    if (act !== ea && act !== eb) begin
      bad++;
      $display("FAIL slot_seg[%0d]: got %02h expected %02h (or %02h)", idx, act, ea, eb);
    end
  endtask

  // Reference display contents from plain arithmetic on the value.
  function automatic disp_t model_display(input int v, input bit hex, input bit blank);
    disp_t r;
    int    d[4];
    bit    all_zero;
    if (hex) begin
      d[0] = v % 16; d[1] = v / 16; d[2] = 0; d[3] = 0;
    end else begin
      d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = v / 100; d[3] = 0;
    end
    all_zero = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      all_zero = all_zero && (d[i] == 0);
      r[i] = (blank && i > 0 && all_zero) ? 7'h7F : ref_seg[d[i]];
    end
    return r;
  endfunction

  task automatic push_exp(input disp_t a, input disp_t b);
    exp_t e;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Counts consecutive busy-high cycles starting at the next negedge.
  task automatic busy_run(input int exp_len, input string name);
    int n = 0;
    @(negedge boardCLK);
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge boardCLK);
    end
    check(name, n, exp_len);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || slots_left != 0) && n < 200) begin
      n++;
      @(negedge boardCLK);
    end
    check({name, "_drain"}, int'(n < 200), 1);
  endtask

  task automatic apply(input int v, input bit hex, input bit blank, input string tag);
    int exp_len;
    @(negedge boardCLK);
    exp_len    = (v != cap_v || hex != cap_hex) ? (hex ? 2 : 10) : 0;
    valueIn    = DW'(v);
    hexMode    = hex;
    blankZeros = blank;
    busy_run(exp_len, {tag, "_busy"});
    cap_v   = v;
    cap_hex = hex;
    push_exp(model_display(v, hex, blank), model_display(v, hex, blank));
    wait_drain(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every new scan slot is an output event.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [ND-1:0] prev_an;
    int            prev_idx;
    int            dur;
    int            idx;
    exp_t          cur;
    prev_an  = '1;
    prev_idx = -1;
    dur      = 0;
    forever begin
      @(negedge boardCLK);
      if (reset === 1'b1) begin
        prev_an  = '1;
        prev_idx = -1;
        dur      = 0;
        continue;
      end
      dur++;
      if (anodes !== prev_an) begin
        if (anodes === '1) begin
          prev_idx = -1;
        end else begin
          idx = -1;
          for (int i = 0; i < ND; i++) if (anodes === ~(ND'(1) << i)) idx = i;
          check("anode_onehot", int'(idx >= 0), 1);
          if (idx >= 0) begin
            if (prev_idx >= 0) begin
              check("scan_order", idx, (prev_idx + 1) % ND);
              check("slot_len", dur, RC);
            end
            if (slots_left == 0 && exp_q.size() > 0) begin
              cur        = exp_q.pop_front();
              slots_left = ND;
            end
            if (slots_left > 0) begin
              check_slot(idx, segments, cur.a[idx], cur.b[idx]);
              slots_left--;
            end
            prev_idx = idx;
          end
        end
        prev_an = anodes;
        dur     = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int n;
    reset      = 1'b1;
    valueIn    = '0;
    hexMode    = 1'b0;
    blankZeros = 1'b0;
    repeat (3) @(posedge boardCLK);
    @(negedge boardCLK);
    check("rst_anodes", int'(anodes), 'hF);
    check("rst_segments", int'(segments), 'h7F);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Dirty flag forces conversion of the value present at reset release.
    busy_run(10, "post_reset_busy");
    cap_v   = 0;
    cap_hex = 1'b0;
    push_exp(model_display(0, 0, 0), model_display(0, 0, 0));
    wait_drain("post_reset");

    apply(255, 0, 0, "dec255");
    apply('hA7, 1, 1, "hexA7");
    apply(7, 0, 1, "dec7_blank");
    apply(7, 0, 0, "blank_only");      // no conversion, only blanking changes
    apply(7, 1, 0, "mode_only");       // same value, new mode reconverts

    // Value change during the third SHIFT cycle.
    @(negedge boardCLK);
    valueIn    = DW'(100);
    hexMode    = 1'b0;
    blankZeros = 1'b0;
    repeat (4) @(posedge boardCLK);
    @(negedge boardCLK);
    valueIn = DW'(42);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge boardCLK);
    end
    check("mid_first_busy", n, 7);
    push_exp(model_display(100, 0, 0), model_display(42, 0, 0));
    busy_run(10, "mid_second_busy");
    push_exp(model_display(42, 0, 0), model_display(42, 0, 0));
    cap_v   = 42;
    cap_hex = 1'b0;
    wait_drain("mid_change");

    // Reset in the middle of SHIFT.
    @(negedge boardCLK);
    valueIn = DW'(200);
    repeat (3) @(posedge boardCLK);
    @(negedge boardCLK);
    reset = 1'b1;
    @(posedge boardCLK);
    @(negedge boardCLK);
    check("midrst_busy", int'(busy), 0);
    check("midrst_anodes", int'(anodes), 'hF);
    check("midrst_segments", int'(segments), 'h7F);
    reset = 1'b0;
    busy_run(10, "midrst_reconv_busy");
    cap_v   = 200;
    cap_hex = 1'b0;
    push_exp(model_display(200, 0, 0), model_display(200, 0, 0));
    wait_drain("midrst");

    for (int t = 0; t < 20; t++) begin
      apply(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
